// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared sizing and grant encoding for the SRAM-backed FIFO controller.
package fifo_package;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 3;
  localparam int SRAM_DEPTH = 8;

  // Occupancy spans SRAM entries + in-flight read + 2 output-buffer slots.
  localparam int FIFO_CNT_W = $clog2(SRAM_DEPTH + 3);

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_RD,
    GNT_WR
  } fifo_gnt_e;

endpackage

// File: rtl/sram.sv
// Single-port synchronous SRAM: write or registered read each cycle, 1-cycle read latency.
module sram
  import fifo_package::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DEPTH  = SRAM_DEPTH
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: storage arrays carry no reset; clearing them would prevent macro mapping.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else begin
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/sram_fifo_ctrl_out_buf.sv
// Two-entry in-order output buffer fed by SRAM read returns, drained by the pop handshake.
module fifo_out_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              wr_valid_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              pop_valid_o,
  output logic [DATA_W-1:0] pop_data_o,
  input  logic              pop_ready_i,
  output logic [1:0]        ob_cnt_o
);

  logic [DATA_W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              pop;

  assign pop         = (cnt_q != 2'd0) && pop_ready_i;
  assign pop_valid_o = (cnt_q != 2'd0);
  assign pop_data_o  = e0_q;
  assign ob_cnt_o    = cnt_q;

  // NOTE: next-state logic uses blocking '=' with defaults first (no latches); the register block uses '<='.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    unique case ({pop, wr_valid_i})
      2'b01: begin
        if (cnt_q == 2'd0) e0_d = wr_data_i;
        else               e1_d = wr_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b10: begin
        if (cnt_q == 2'd2) e0_d = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          e0_d = e1_q;
          e1_d = wr_data_i;
        end else begin
          e0_d = wr_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller using a single-port SRAM as storage; one SRAM access per cycle chosen by an arbiter.
module sram_fifo_ctrl
  import fifo_package::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DEPTH  = SRAM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  push_valid_i,
  input  logic [DATA_W-1:0]     push_data_i,
  output logic                  push_ready_o,
  output logic                  pop_valid_o,
  output logic [DATA_W-1:0]     pop_data_o,
  input  logic                  pop_ready_i,
  output logic [ADDR_W-1:0]     sram_addr_o,
  output logic [DATA_W-1:0]     sram_wdata_o,
  output logic                  sram_we_o,
  input  logic [DATA_W-1:0]     sram_rdata_i,
  output logic [FIFO_CNT_W-1:0] count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0] mem_cnt_q, mem_cnt_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic [1:0]            ob_cnt, ob_load;
  logic                  mem_full, mem_empty, starve;
  fifo_gnt_e             gnt;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
  endfunction

  assign mem_full  = (mem_cnt_q == FIFO_CNT_W'(DEPTH));
  assign mem_empty = (mem_cnt_q == '0);
  assign ob_load   = ob_cnt + {1'b0, rd_inflight_q};
  // A drained output side preempts writes so the head never stalls behind pushes.
  assign starve    = !mem_empty && (ob_load == 2'd0);

  assign push_ready_o = !mem_full && !starve;

  always_comb begin
    gnt = GNT_IDLE;
    if (starve)                                gnt = GNT_RD;
    else if (push_valid_i && !mem_full)        gnt = GNT_WR;
    else if (!mem_empty && (ob_load < 2'd2))   gnt = GNT_RD;
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    mem_cnt_d     = mem_cnt_q;
    rd_inflight_d = 1'b0;
    unique case (gnt)
      GNT_WR: begin
        wr_ptr_d  = ptr_inc(wr_ptr_q);
        mem_cnt_d = mem_cnt_q + FIFO_CNT_W'(1);
      end
      GNT_RD: begin
        rd_ptr_d      = ptr_inc(rd_ptr_q);
        mem_cnt_d     = mem_cnt_q - FIFO_CNT_W'(1);
        rd_inflight_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign sram_we_o    = (gnt == GNT_WR);
  assign sram_addr_o  = (gnt == GNT_WR) ? wr_ptr_q : rd_ptr_q;
  assign sram_wdata_o = push_data_i;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mem_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_cnt_q     <= mem_cnt_d;
      rd_inflight_q <= rd_inflight_d;
    end
  end

  fifo_out_buf #(
    .DATA_W (DATA_W)
  ) u_out_buf (
    .clk         (clk),
    .rst_ni      (rst_ni),
    .wr_valid_i  (rd_inflight_q),
    .wr_data_i   (sram_rdata_i),
    .pop_valid_o (pop_valid_o),
    .pop_data_o  (pop_data_o),
    .pop_ready_i (pop_ready_i),
    .ob_cnt_o    (ob_cnt)
  );

  assign count_o = mem_cnt_q + FIFO_CNT_W'(rd_inflight_q) + FIFO_CNT_W'(ob_cnt);
  assign full_o  = mem_full;
  assign empty_o = (count_o == '0);

endmodule
